// File: rtl/wb_sram_arb2.sv
// wb_sram_arb2: two-master to one-slave Wishbone arbiter for the shared SRAM.
// m0 is the instruction-fetch port, m1 the data load/store port. Grants are
// round-robin, held for one whole transaction, and separated by at least one
// IDLE cycle so the slave's own IDLE/ACK sequencing stays aligned.
//
// Handshake: a master requests by holding stb high with adr/sel/we/dat stable.
// The slave answers with a single-cycle ack (read data valid in that cycle).
// A transfer completes in the cycle where the granted master's ack is high;
// err instead of ack means the slave never answered within TMO_CYC cycles.
// Dropping stb while granted abandons the transfer and any late slave ack
// lands in IDLE, where it is ignored.
module wb_sram_arb2 #(
    parameter int ASIZE   = 14,
    parameter int DSIZE   = 32,
    parameter int TMO_CYC = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    // master 0 (instruction fetch)
    input  logic [ASIZE-1:0]     i_m0_adr,
    input  logic                 i_m0_stb,
    input  logic [DSIZE/8-1:0]   i_m0_sel,
    input  logic                 i_m0_we,
    input  logic [DSIZE-1:0]     i_m0_dat,
    output logic                 o_m0_ack,
    output logic                 o_m0_err,
    output logic [DSIZE-1:0]     o_m0_dat,
    // master 1 (data load/store)
    input  logic [ASIZE-1:0]     i_m1_adr,
    input  logic                 i_m1_stb,
    input  logic [DSIZE/8-1:0]   i_m1_sel,
    input  logic                 i_m1_we,
    input  logic [DSIZE-1:0]     i_m1_dat,
    output logic                 o_m1_ack,
    output logic                 o_m1_err,
    output logic [DSIZE-1:0]     o_m1_dat,
    // slave (SRAM)
    output logic [ASIZE-1:0]     o_s_adr,
    output logic                 o_s_stb,
    output logic [DSIZE/8-1:0]   o_s_sel,
    output logic                 o_s_we,
    output logic [DSIZE-1:0]     o_s_dat,
    input  logic                 i_s_ack,
    input  logic [DSIZE-1:0]     i_s_dat,
    // status
    output logic [1:0]           o_gnt,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    // Counter value in the cycle that times out (entry cycle counts as 0).
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t     state;
    logic       last_m1;   // 1 when m1 held the most recent grant
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       cur_stb;

    // Timeout fires only without an ack in the same cycle: ack wins a tie.
    always_comb begin
        tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_LAST) && !i_s_ack;
        cur_stb = 1'b0;
        if (state == S_GNT0) cur_stb = i_m0_stb;
        if (state == S_GNT1) cur_stb = i_m1_stb;
    end

    // Arbitration FSM with last-grant memory and the per-transaction watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            last_m1 <= 1'b1;
            tmo_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (i_m0_stb && i_m1_stb) begin
                        if (last_m1) begin
                            state   <= S_GNT0;
                            last_m1 <= 1'b0;
                        end else begin
                            state   <= S_GNT1;
                            last_m1 <= 1'b1;
                        end
                    end else if (i_m0_stb) begin
                        state   <= S_GNT0;
                        last_m1 <= 1'b0;
                    end else if (i_m1_stb) begin
                        state   <= S_GNT1;
                        last_m1 <= 1'b1;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (i_s_ack || !cur_stb || tmo_hit) begin
                        state   <= S_IDLE;
                        tmo_cnt <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tmo_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Slave-side mux and master-side ack/err routing, decoded from state.
    always_comb begin
        o_s_adr  = '0;
        o_s_stb  = 1'b0;
        o_s_sel  = '0;
        o_s_we   = 1'b0;
        o_s_dat  = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        case (state)
            S_GNT0: begin
                o_s_adr  = i_m0_adr;
                o_s_stb  = i_m0_stb;
                o_s_sel  = i_m0_sel;
                o_s_we   = i_m0_we;
                o_s_dat  = i_m0_dat;
                o_m0_ack = i_s_ack;
                o_m0_err = tmo_hit;
            end
            S_GNT1: begin
                o_s_adr  = i_m1_adr;
                o_s_stb  = i_m1_stb;
                o_s_sel  = i_m1_sel;
                o_s_we   = i_m1_we;
                o_s_dat  = i_m1_dat;
                o_m1_ack = i_s_ack;
                o_m1_err = tmo_hit;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign o_m0_dat = i_s_dat;
    assign o_m1_dat = i_s_dat;
    assign o_gnt    = {state == S_GNT1, state == S_GNT0};
    assign o_state  = state;

endmodule

// File: tb/tb_wb_sram_arb2.sv
// tb_wb_sram_arb2: directed bench for the two-master SRAM arbiter.
// Inputs change 1 ns after the rising edge; outputs are checked after that.
module tb_wb_sram_arb2;

    logic        i_clk;
    logic        i_rst_n;
    logic [13:0] i_m0_adr;
    logic        i_m0_stb;
    logic [3:0]  i_m0_sel;
    logic        i_m0_we;
    logic [31:0] i_m0_dat;
    logic        o_m0_ack;
    logic        o_m0_err;
    logic [31:0] o_m0_dat;
    logic [13:0] i_m1_adr;
    logic        i_m1_stb;
    logic [3:0]  i_m1_sel;
    logic        i_m1_we;
    logic [31:0] i_m1_dat;
    logic        o_m1_ack;
    logic        o_m1_err;
    logic [31:0] o_m1_dat;
    logic [13:0] o_s_adr;
    logic        o_s_stb;
    logic [3:0]  o_s_sel;
    logic        o_s_we;
    logic [31:0] o_s_dat;
    logic        i_s_ack;
    logic [31:0] i_s_dat;
    logic [1:0]  o_gnt;
    logic [1:0]  o_state;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    wb_sram_arb2 #(.ASIZE(14), .DSIZE(32), .TMO_CYC(15)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_adr(i_m0_adr), .i_m0_stb(i_m0_stb), .i_m0_sel(i_m0_sel),
        .i_m0_we(i_m0_we), .i_m0_dat(i_m0_dat),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_dat(o_m0_dat),
        .i_m1_adr(i_m1_adr), .i_m1_stb(i_m1_stb), .i_m1_sel(i_m1_sel),
        .i_m1_we(i_m1_we), .i_m1_dat(i_m1_dat),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_dat(o_m1_dat),
        .o_s_adr(o_s_adr), .o_s_stb(o_s_stb), .o_s_sel(o_s_sel),
        .o_s_we(o_s_we), .o_s_dat(o_s_dat),
        .i_s_ack(i_s_ack), .i_s_dat(i_s_dat),
        .o_gnt(o_gnt), .o_state(o_state)
    );

    // clock / reset block
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_m0_adr = '0; i_m0_stb = 0; i_m0_sel = '0; i_m0_we = 0; i_m0_dat = '0;
        i_m1_adr = '0; i_m1_stb = 0; i_m1_sel = '0; i_m1_we = 0; i_m1_dat = '0;
        i_s_ack = 0; i_s_dat = '0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        #3;
        n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", o_gnt); end
        n_vec++; if (o_s_stb !== 1'b0) begin n_err++; $display("FAIL rst_s_stb: got %b want 0", o_s_stb); end
        n_vec++; if ({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0000) begin
            n_err++; $display("FAIL rst_ack_err: got %b want 0000", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}); end
        n_vec++; if (o_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", o_state); end
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        i_m0_adr = 14'h0010; i_m0_sel = 4'hF; i_m0_we = 0; i_m0_stb = 1;
        #1;
        n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL rd_pre_gnt: got %b want 00", o_gnt); end
        next_cycle();
        n_vec++; if (o_gnt !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b want 01", o_gnt); end
        n_vec++; if (o_s_adr !== 14'h0010) begin n_err++; $display("FAIL rd_s_adr: got %h want 0010", o_s_adr); end
        n_vec++; if (o_s_stb !== 1'b1 || o_s_we !== 1'b0) begin
            n_err++; $display("FAIL rd_s_stb_we: got %b%b want 10", o_s_stb, o_s_we); end
        n_vec++; if (o_m0_ack !== 1'b0) begin n_err++; $display("FAIL rd_early_ack: got %b want 0", o_m0_ack); end
        next_cycle();
        i_s_ack = 1; i_s_dat = 32'hDEADBEEF;
        #1;
        n_vec++; if (o_m0_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", o_m0_ack); end
        n_vec++; if (o_m0_dat !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_dat: got %h want deadbeef", o_m0_dat); end
        n_vec++; if (o_m1_ack !== 1'b0 || o_m1_dat !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL rd_m1_side: got ack %b dat %h want 0 deadbeef", o_m1_ack, o_m1_dat); end
        next_cycle();
        i_s_ack = 0; i_m0_stb = 0;
        #1;
        n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL rd_idle_gnt: got %b want 00", o_gnt); end
        n_vec++; if (o_s_adr !== 14'h0000 || o_s_stb !== 1'b0) begin
            n_err++; $display("FAIL rd_idle_s: got adr %h stb %b want 0000 0", o_s_adr, o_s_stb); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        int n_ack0;
        int n_ack1;
        n_ack0 = 0; n_ack1 = 0;
        idle_inputs();
        do_reset();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        i_m0_adr = 14'h0100; i_m0_sel = 4'hF; i_m0_stb = 1;
        i_m1_adr = 14'h0200; i_m1_sel = 4'hF; i_m1_stb = 1;
        for (int t = 0; t < 4; t++) begin
            exp_g = exp_q.pop_front();
            next_cycle();
            n_vec++; if (o_gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", t, o_gnt, exp_g); end
            n_vec++; if (o_s_adr !== ((exp_g == 2'b01) ? 14'h0100 : 14'h0200)) begin
                n_err++; $display("FAIL rr_adr%0d: got %h want %h", t, o_s_adr, (exp_g == 2'b01) ? 14'h0100 : 14'h0200); end
            next_cycle();
            i_s_ack = 1; i_s_dat = 32'hA000_0000 + 32'(t);
            #1;
            n_vec++; if ({o_m1_ack, o_m0_ack} !== exp_g) begin
                n_err++; $display("FAIL rr_ack%0d: got %b want %b", t, {o_m1_ack, o_m0_ack}, exp_g); end
            n_ack0 += int'(o_m0_ack);
            n_ack1 += int'(o_m1_ack);
            next_cycle();
            i_s_ack = 0;
            #1;
            n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL rr_idle%0d: got %b want 00", t, o_gnt); end
        end
        n_vec++; if (n_ack0 != 2 || n_ack1 != 2) begin
            n_err++; $display("FAIL rr_ack_count: got %0d/%0d want 2/2", n_ack0, n_ack1); end
        i_m0_stb = 0; i_m1_stb = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_write();
        i_m1_adr = 14'h3FFF; i_m1_sel = 4'b0101; i_m1_we = 1; i_m1_dat = 32'h11223344; i_m1_stb = 1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            if (c == 1) begin i_s_ack = 1; #1; end
            n_vec++; if (o_gnt !== 2'b10) begin n_err++; $display("FAIL wr_gnt%0d: got %b want 10", c, o_gnt); end
            n_vec++; if (o_s_adr !== 14'h3FFF || o_s_sel !== 4'b0101 || o_s_we !== 1'b1 || o_s_dat !== 32'h11223344) begin
                n_err++; $display("FAIL wr_slave%0d: got %h %b %b %h want 3fff 0101 1 11223344", c, o_s_adr, o_s_sel, o_s_we, o_s_dat); end
            n_vec++; if ({o_m1_ack, o_m0_ack} !== ((c == 1) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL wr_ack%0d: got %b want %b", c, {o_m1_ack, o_m0_ack}, (c == 1) ? 2'b10 : 2'b00); end
        end
        next_cycle();
        i_s_ack = 0; i_m1_stb = 0; i_m1_we = 0;
        #1;
        n_vec++; if (o_gnt !== 2'b00 || o_s_we !== 1'b0) begin
            n_err++; $display("FAIL wr_idle: got gnt %b we %b want 00 0", o_gnt, o_s_we); end
        next_cycle();
    endtask

    task automatic test_timeout();
        i_m0_adr = 14'h0044; i_m0_stb = 1;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            n_vec++; if (o_gnt !== 2'b01) begin n_err++; $display("FAIL tmo_gnt%0d: got %b want 01", k, o_gnt); end
            n_vec++; if (o_m0_err !== (k == 14)) begin
                n_err++; $display("FAIL tmo_err%0d: got %b want %b", k, o_m0_err, k == 14); end
            n_vec++; if (o_m0_ack !== 1'b0) begin n_err++; $display("FAIL tmo_ack%0d: got %b want 0", k, o_m0_ack); end
        end
        i_m0_stb = 0; i_m1_adr = 14'h0055; i_m1_stb = 1;
        next_cycle();
        n_vec++; if (o_gnt !== 2'b00 || o_m0_err !== 1'b0) begin
            n_err++; $display("FAIL tmo_idle: got gnt %b err %b want 00 0", o_gnt, o_m0_err); end
        next_cycle();
        n_vec++; if (o_gnt !== 2'b10) begin n_err++; $display("FAIL tmo_next_gnt: got %b want 10", o_gnt); end
        next_cycle();
        i_s_ack = 1;
        #1;
        n_vec++; if (o_m1_ack !== 1'b1) begin n_err++; $display("FAIL tmo_next_ack: got %b want 1", o_m1_ack); end
        next_cycle();
        i_s_ack = 0; i_m1_stb = 0;
        next_cycle();
    endtask

    task automatic test_tmo_ack_race();
        i_m1_adr = 14'h0066; i_m1_stb = 1;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            if (k == 14) begin i_s_ack = 1; #1; end
            n_vec++; if (o_m1_err !== 1'b0) begin n_err++; $display("FAIL race_err%0d: got %b want 0", k, o_m1_err); end
            n_vec++; if (o_m1_ack !== (k == 14)) begin
                n_err++; $display("FAIL race_ack%0d: got %b want %b", k, o_m1_ack, k == 14); end
        end
        next_cycle();
        i_s_ack = 0; i_m1_stb = 0;
        #1;
        n_vec++; if (o_gnt !== 2'b00 || o_m1_err !== 1'b0) begin
            n_err++; $display("FAIL race_idle: got gnt %b err %b want 00 0", o_gnt, o_m1_err); end
        next_cycle();
    endtask

    task automatic test_abort();
        i_m0_adr = 14'h0077; i_m0_stb = 1;
        next_cycle();
        n_vec++; if (o_gnt !== 2'b01) begin n_err++; $display("FAIL ab_gnt: got %b want 01", o_gnt); end
        next_cycle();
        i_m0_stb = 0;
        #1;
        n_vec++; if (o_s_stb !== 1'b0 || o_gnt !== 2'b01) begin
            n_err++; $display("FAIL ab_drop: got stb %b gnt %b want 0 01", o_s_stb, o_gnt); end
        next_cycle();
        i_s_ack = 1;
        #1;
        n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL ab_idle: got %b want 00", o_gnt); end
        n_vec++; if ({o_m0_ack, o_m1_ack, o_m0_err, o_m1_err} !== 4'b0000) begin
            n_err++; $display("FAIL ab_stray_ack: got %b want 0000", {o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}); end
        next_cycle();
        i_s_ack = 0;
        #1;
        n_vec++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL ab_stay_idle: got %b want 00", o_gnt); end
    endtask

    task automatic test_reset_mid();
        i_m1_adr = 14'h0123; i_m1_stb = 1;
        next_cycle();
        n_vec++; if (o_gnt !== 2'b10) begin n_err++; $display("FAIL rm_gnt: got %b want 10", o_gnt); end
        #2;
        i_rst_n = 0; i_s_ack = 1;
        #1;
        n_vec++; if (o_gnt !== 2'b00 || o_s_stb !== 1'b0) begin
            n_err++; $display("FAIL rm_async: got gnt %b stb %b want 00 0", o_gnt, o_s_stb); end
        n_vec++; if (o_m1_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack: got %b want 0", o_m1_ack); end
        next_cycle();
        i_rst_n = 1; i_s_ack = 0; i_m0_adr = 14'h0321; i_m0_stb = 1;
        next_cycle();
        n_vec++; if (o_gnt !== 2'b01) begin n_err++; $display("FAIL rm_first_contend: got %b want 01", o_gnt); end
        next_cycle();
        i_s_ack = 1;
        next_cycle();
        i_s_ack = 0; i_m0_stb = 0; i_m1_stb = 0;
        next_cycle();
    endtask

    // test sequence and final report
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_tmo_ack_race();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
